// File: rtl/exe_pkg.sv
// Shared opcode, instruction-type and FSM state definitions for the
// registered execute stage.
package exe_pkg;

    localparam logic [3:0] COMP_ADD = 4'd0;
    localparam logic [3:0] COMP_SUB = 4'd1;
    localparam logic [3:0] COMP_AND = 4'd2;
    localparam logic [3:0] COMP_OR  = 4'd3;
    localparam logic [3:0] COMP_XOR = 4'd4;
    localparam logic [3:0] COMP_SLL = 4'd5;
    localparam logic [3:0] COMP_SRL = 4'd6;
    localparam logic [3:0] COMP_SRA = 4'd7;
    localparam logic [3:0] COMP_MUL = 4'd8;

    localparam logic [3:0] COND_EQ  = 4'd0;
    localparam logic [3:0] COND_NE  = 4'd1;
    localparam logic [3:0] COND_LT  = 4'd2;
    localparam logic [3:0] COND_GE  = 4'd3;
    localparam logic [3:0] COND_LTU = 4'd4;
    localparam logic [3:0] COND_GEU = 4'd5;

    localparam logic [1:0] ITYPE_R   = 2'b00;
    localparam logic [1:0] ITYPE_BR  = 2'b01;
    localparam logic [1:0] ITYPE_I   = 2'b10;
    localparam logic [1:0] ITYPE_RSV = 2'b11;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: XLEN/MUL_CYCLES multiplier bits per step,
// low XLEN bits of the unsigned product.
module exe_mul_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            step,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] product,
    output logic            done
);

    localparam int unsigned STEP = XLEN / MUL_CYCLES;
    localparam int unsigned CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] sum;

    // product is the accumulator after this step, so the final step's
    // contribution is visible on the same edge the stage captures it.
    always_comb begin
        sum = acc;
        for (int unsigned j = 0; j < STEP; j++) begin
            if (mplier[j]) begin
                sum = sum + (mcand << j);
            end
        end
    end

    always_comb begin
        product = sum;
        done    = step && (count == CW'(MUL_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= sum;
            mcand  <= mcand << STEP;
            mplier <= mplier >> STEP;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/exe_pipe_stage.sv
// Registered execute stage: operand/opcode selection, computational and
// conditional ALU, branch target, valid/ready handshakes and iterative MUL.
module exe_pipe_stage
    import exe_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_BITS   = 4,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     rs1_val,
    input  logic [XLEN-1:0]     rs2_val,
    input  logic [1:0]          instr_type,
    input  logic                is_computational,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                needs_wb,
    input  logic [REG_BITS-1:0] rs2,
    input  logic [REG_BITS-1:0] rd,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     pc_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                z_flag,
    output logic [XLEN-1:0]     exe_out,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     store_data,
    output logic                needs_wb_out,
    output logic                is_load_out,
    output logic                is_store_out,
    output logic [REG_BITS-1:0] wb_addr
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_t              state;
    logic [XLEN-1:0]     op2;
    logic [3:0]          opcode;
    logic [XLEN-1:0]     alu_out;
    logic                cond_z;
    logic [XLEN-1:0]     exe_next;
    logic                z_next;
    logic                is_mul_op;
    logic                accept;
    logic [XLEN-1:0]     mul_product;
    logic                mul_done;

    logic [XLEN-1:0]     h_pc;
    logic [XLEN-1:0]     h_store_data;
    logic [REG_BITS-1:0] h_rd;
    logic                h_needs_wb;
    logic                h_is_load;
    logic                h_is_store;

    always_comb begin
        op2 = (instr_type[1] || is_load || is_store) ? imm : rs2_val;
        case (instr_type)
            ITYPE_R:  opcode = imm[3:0];
            ITYPE_BR: opcode = rd[3:0];
            ITYPE_I:  opcode = rs2[3:0];
            default:  opcode = '0;
        endcase
    end

    always_comb begin
        case (opcode)
            COMP_ADD: alu_out = rs1_val + op2;
            COMP_SUB: alu_out = rs1_val - op2;
            COMP_AND: alu_out = rs1_val & op2;
            COMP_OR:  alu_out = rs1_val | op2;
            COMP_XOR: alu_out = rs1_val ^ op2;
            COMP_SLL: alu_out = rs1_val << op2[SHW-1:0];
            COMP_SRL: alu_out = rs1_val >> op2[SHW-1:0];
            COMP_SRA: alu_out = $unsigned($signed(rs1_val) >>> op2[SHW-1:0]);
            // Only a single-cycle configuration multiplies inline.
            COMP_MUL: alu_out = (MUL_CYCLES == 1) ? rs1_val * op2 : '0;
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        case (opcode)
            COND_EQ:  cond_z = (rs1_val == op2);
            COND_NE:  cond_z = (rs1_val != op2);
            COND_LT:  cond_z = ($signed(rs1_val) <  $signed(op2));
            COND_GE:  cond_z = ($signed(rs1_val) >= $signed(op2));
            COND_LTU: cond_z = (rs1_val <  op2);
            COND_GEU: cond_z = (rs1_val >= op2);
            default:  cond_z = 1'b0;
        endcase
    end

    always_comb begin
        z_next    = is_computational ? 1'b0 : cond_z;
        exe_next  = is_computational ? alu_out : pc_in + imm;
        is_mul_op = (MUL_CYCLES > 1) && is_computational && (opcode == COMP_MUL);
        in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
        accept    = in_valid && in_ready;
    end

    exe_mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul_op),
        .abort   (flush),
        .step    (state == MUL_BUSY),
        .a       (rs1_val),
        .b       (op2),
        .product (mul_product),
        .done    (mul_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            z_flag       <= 1'b0;
            exe_out      <= '0;
            pc_out       <= '0;
            store_data   <= '0;
            needs_wb_out <= 1'b0;
            is_load_out  <= 1'b0;
            is_store_out <= 1'b0;
            wb_addr      <= '0;
            h_pc         <= '0;
            h_store_data <= '0;
            h_rd         <= '0;
            h_needs_wb   <= 1'b0;
            h_is_load    <= 1'b0;
            h_is_store   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul_op) begin
                        state        <= MUL_BUSY;
                        out_valid    <= 1'b0;
                        h_pc         <= pc_in;
                        h_store_data <= rs2_val;
                        h_rd         <= rd;
                        h_needs_wb   <= needs_wb;
                        h_is_load    <= is_load;
                        h_is_store   <= is_store;
                    end else if (accept) begin
                        out_valid    <= 1'b1;
                        z_flag       <= z_next;
                        exe_out      <= exe_next;
                        pc_out       <= pc_in;
                        store_data   <= rs2_val;
                        needs_wb_out <= needs_wb;
                        is_load_out  <= is_load;
                        is_store_out <= is_store;
                        wb_addr      <= rd;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        state        <= IDLE;
                        out_valid    <= 1'b1;
                        z_flag       <= 1'b0;
                        exe_out      <= mul_product;
                        pc_out       <= h_pc;
                        store_data   <= h_store_data;
                        needs_wb_out <= h_needs_wb;
                        is_load_out  <= h_is_load;
                        is_store_out <= h_is_store;
                        wb_addr      <= h_rd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_pipe_stage.sv
// Directed-vector bench for exe_pipe_stage with hand-computed expectations.
module tb_exe_pipe_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] rs1_val, rs2_val, imm, pc_in;
    logic [1:0]  instr_type;
    logic        is_computational, is_load, is_store, needs_wb;
    logic [3:0]  rs2, rd;
    logic        out_valid, out_ready, z_flag;
    logic [31:0] exe_out, pc_out, store_data;
    logic        needs_wb_out, is_load_out, is_store_out;
    logic [3:0]  wb_addr;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    typedef struct {
        logic [1:0]  t;
        logic        comp, ld, st, wb;
        logic [3:0]  r2, rdv;
        logic [31:0] a, b, im, pc, exp;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    exe_pipe_stage #(
        .XLEN       (32),
        .REG_BITS   (4),
        .MUL_CYCLES (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .instr_type       (instr_type),
        .is_computational (is_computational),
        .is_load          (is_load),
        .is_store         (is_store),
        .needs_wb         (needs_wb),
        .rs2              (rs2),
        .rd               (rd),
        .imm              (imm),
        .pc_in            (pc_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .z_flag           (z_flag),
        .exe_out          (exe_out),
        .pc_out           (pc_out),
        .store_data       (store_data),
        .needs_wb_out     (needs_wb_out),
        .is_load_out      (is_load_out),
        .is_store_out     (is_store_out),
        .wb_addr          (wb_addr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic comp, input logic ld, input logic st,
                         input logic wb, input logic [3:0] r2, input logic [3:0] rdv,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] pc);
        instr_type       = t;
        is_computational = comp;
        is_load          = ld;
        is_store         = st;
        needs_wb         = wb;
        rs2              = r2;
        rd               = rdv;
        rs1_val          = a;
        rs2_val          = b;
        imm              = im;
        pc_in            = pc;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_exe"},   64'(exe_out),   64'd0);
        check_val({tag, "_z"},     64'(z_flag),    64'd0);
        check_val({tag, "_pc"},    64'(pc_out),    64'd0);
        check_val({tag, "_sd"},    64'(store_data), 64'd0);
        check_val({tag, "_wba"},   64'(wb_addr),   64'd0);
        check_val({tag, "_flags"}, 64'({needs_wb_out, is_load_out, is_store_out}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // type comp ld st wb rs2 rd rs1 rs2_val imm pc expected z
        vecs.push_back('{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 32'd5,         32'd7,         32'd0,         32'h0,   32'd12,        1'b0});
        vecs.push_back('{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 32'hFFFFFFFF,  32'd1,         32'h20,        32'h100, 32'h120,       1'b1});
        vecs.push_back('{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 32'hFFFFFFFF,  32'd1,         32'h20,        32'h100, 32'h120,       1'b0});
        vecs.push_back('{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd1, 32'h80000000,  32'd0,         32'd31,        32'h0,   32'hFFFFFFFF,  1'b0});
        vecs.push_back('{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd5, 32'd5,         32'd0,         32'd7,         32'h0,   32'hFFFFFFFE,  1'b0});
        vecs.push_back('{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd6, 32'h0000F0F0,  32'h0000FF00,  32'd4,         32'h0,   32'h00000FF0,  1'b0});
        vecs.push_back('{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 32'hFF00FF00,  32'h0FF00FF0,  32'd2,         32'h0,   32'h0F000F00,  1'b0});
        vecs.push_back('{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 32'hFF00FF00,  32'h0FF00FF0,  32'd3,         32'h0,   32'hFFF0FFF0,  1'b0});
        vecs.push_back('{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd8, 32'd1,         32'd0,         32'd31,        32'h0,   32'h80000000,  1'b0});
        vecs.push_back('{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd9, 32'h80000000,  32'd0,         32'd4,         32'h0,   32'h08000000,  1'b0});
        vecs.push_back('{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd3, 32'd4,         32'd99,        32'd6,         32'h0,   32'd10,        1'b0});
        vecs.push_back('{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 32'd3,         32'd4,         32'd9,         32'h0,   32'd0,         1'b0});
        vecs.push_back('{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd9,         32'd9,         32'hFFFFFFF0,  32'h200, 32'h1F0,       1'b1});
        vecs.push_back('{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6, 32'd1,         32'd1,         32'd8,         32'h0,   32'd8,         1'b0});
        vecs.push_back('{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 32'hFFFFFFFE,  32'hFFFFFFFF,  32'd4,         32'h40,  32'h44,        1'b0});
        vecs.push_back('{2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 32'h1000,      32'hDEAD,      32'd4,         32'h80,  32'h1004,      1'b0});
        vecs.push_back('{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 32'h2000,      32'hBEEF,      32'd0,         32'h84,  32'h2000,      1'b0});

        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        #1;
        check_val("reset_in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ops, one per cycle back to back
        foreach (vecs[i]) begin
            drive(vecs[i].t, vecs[i].comp, vecs[i].ld, vecs[i].st, vecs[i].wb,
                  vecs[i].r2, vecs[i].rdv, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].pc);
            in_valid = 1'b1;
            #1;
            check_val($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            tick();
            check_val($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check_val($sformatf("v%0d_exe", i),   64'(exe_out), 64'(vecs[i].exp));
            check_val($sformatf("v%0d_z", i),     64'(z_flag), 64'(vecs[i].z));
            check_val($sformatf("v%0d_pc", i),    64'(pc_out), 64'(vecs[i].pc));
            check_val($sformatf("v%0d_sd", i),    64'(store_data), 64'(vecs[i].b));
            check_val($sformatf("v%0d_side", i),
                      64'({wb_addr, needs_wb_out, is_load_out, is_store_out}),
                      64'({vecs[i].rdv, vecs[i].wb, vecs[i].ld, vecs[i].st}));
        end
        in_valid = 1'b0;
        tick();
        check_val("drain_valid", 64'(out_valid), 64'd0);

        // MUL 0x10000 * 0x10001, ADD 1+2 held behind it
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 32'h10000, 32'h10001, 32'd8, 32'h300);
        in_valid = 1'b1;
        tick();
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd10, 32'd1, 32'd2, 32'd0, 32'h304);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("mul_busy%0d_in_ready", i), 64'(in_ready), 64'd0);
            check_val($sformatf("mul_busy%0d_valid", i), 64'(out_valid), 64'd0);
            tick();
        end
        check_val("mul_valid", 64'(out_valid), 64'd1);
        check_val("mul_exe",   64'(exe_out), 64'h10000);
        check_val("mul_pc",    64'(pc_out), 64'h300);
        check_val("mul_wba",   64'(wb_addr), 64'd9);
        check_val("mul_sd",    64'(store_data), 64'h10001);
        check_val("mul_idle_in_ready", 64'(in_ready), 64'd1);
        tick();
        check_val("held_add_valid", 64'(out_valid), 64'd1);
        check_val("held_add_exe",   64'(exe_out), 64'd3);
        check_val("held_add_wba",   64'(wb_addr), 64'd10);

        // Backpressure for three cycles, then back-to-back results
        out_ready = 1'b0;
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd11, 32'd10, 32'd20, 32'd0, 32'h308);
        #1;
        check_val("bp_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("bp%0d_valid", i), 64'(out_valid), 64'd1);
            check_val($sformatf("bp%0d_exe", i), 64'(exe_out), 64'd3);
            check_val($sformatf("bp%0d_wba", i), 64'(wb_addr), 64'd10);
            check_val($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        check_val("b2b0_valid", 64'(out_valid), 64'd1);
        check_val("b2b0_exe",   64'(exe_out), 64'd30);
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd12, 32'd100, 32'd1, 32'd0, 32'h30C);
        tick();
        check_val("b2b1_valid", 64'(out_valid), 64'd1);
        check_val("b2b1_exe",   64'(exe_out), 64'd101);
        in_valid = 1'b0;
        tick();
        check_val("b2b_drain_valid", 64'(out_valid), 64'd0);

        // Flush in the second MUL_BUSY cycle
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 32'd3, 32'd5, 32'd8, 32'h400);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check_val("flush_valid", 64'(out_valid), 64'd0);
        check_val("flush_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("flush_quiet%0d_valid", i), 64'(out_valid), 64'd0);
        end
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 32'd7, 32'd8, 32'd0, 32'h404);
        in_valid = 1'b1;
        tick();
        check_val("post_flush_valid", 64'(out_valid), 64'd1);
        check_val("post_flush_exe",   64'(exe_out), 64'd15);

        // Flush blocks the presented instruction and keeps output data
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 32'd50, 32'd50, 32'd0, 32'h408);
        flush = 1'b1;
        #1;
        check_val("flush_blocks_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_val("flush_kill_valid", 64'(out_valid), 64'd0);
        check_val("flush_keep_exe",   64'(exe_out), 64'd15);
        check_val("flush_keep_wba",   64'(wb_addr), 64'd2);

        // Reset while a result is held under backpressure
        drive(2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 32'd40, 32'hCAFE, 32'd2, 32'h500);
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check_val("pre_rst_valid", 64'(out_valid), 64'd1);
        check_val("pre_rst_exe", 64'(exe_out), 64'd42);
        rst = 1'b1;
        tick();
        check_zero_outputs("rst_held");
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of a MUL
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd6, 32'd6, 32'd7, 32'd8, 32'h600);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_val("rst_mul_busy_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        check_zero_outputs("rst_mul");
        rst = 1'b0;
        #1;
        check_val("rst_mul_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("rst_mul_quiet%0d_valid", i), 64'(out_valid), 64'd0);
        end
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 32'd2, 32'd2, 32'd0, 32'h700);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("post_rst_valid", 64'(out_valid), 64'd1);
        check_val("post_rst_exe",   64'(exe_out), 64'd4);
        check_val("post_rst_wba",   64'(wb_addr), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
